rr_mux_4x1: RTL and testbench

RR_MUX_4X1 -- requirements
Module: rr_mux_4x1

---
 rtl/rr_mux_4x1.sv | 119 +++++++++++
 tb/tb_rr_mux_4x1.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_4x1.sv
// Four-channel round-robin packet multiplexer with a one-beat registered output.
// Arbitration locks onto a channel for the length of a multi-beat packet.
module rr_mux_4x1 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_last,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         lch_q, lch_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [1:0]         out_sel_q, out_sel_d;

    logic               load_en;
    logic [1:0]         grant;
    logic               grant_vld;
    logic [1:0]         idx;
    logic               accept;
    logic               acc_last;

    assign load_en = !out_valid_q || out_ready;

    // In LOCK only the locked channel may be granted, even while it is idle.
    always_comb begin
        grant     = 2'd0;
        grant_vld = 1'b0;
        idx       = 2'd0;
        if (state_q == LOCK) begin
            grant     = lch_q;
            grant_vld = in_valid[lch_q];
        end else begin
            for (int i = 0; i < 4; i++) begin
                idx = ptr_q + 2'(i);
                if (!grant_vld && in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant     = idx;
                end
            end
        end
    end

    // Gating with rst_n keeps in_ready low during reset regardless of clk.
    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && load_en && grant_vld) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign accept   = |in_ready;
    assign acc_last = in_last[grant];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lch_d       = lch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant*WIDTH +: WIDTH];
            out_last_d  = acc_last;
            out_sel_d   = grant;
            if (acc_last) begin
                state_d = IDLE;
                ptr_d   = grant + 2'd1;
            end else if (state_q == IDLE) begin
                state_d = LOCK;
                lch_d   = grant;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            lch_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lch_q       <= lch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Directed table-driven bench for rr_mux_4x1 plus a hand-written async reset sequence.
module tb_rr_mux_4x1;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [1:0]         out_sel;
    logic               out_ready;

    int n_cmp;
    int n_bad;

    rr_mux_4x1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic [1:0]  e_os;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // round robin, all channels valid, single-beat packets
        tbl[0]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 1'b1, 2'd1};
        tbl[2]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b1, 2'd0};
        // drain: out_valid clears, data/sel held
        tbl[5]  = '{4'b0000, 32'h13121110, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h10, 1'b1, 2'd0};
        // ch1 single beat moves ptr to 2
        tbl[6]  = '{4'b0010, 32'h00002100, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h21, 1'b1, 2'd1};
        // ch2 three-beat packet with ch0/ch1 contending
        tbl[7]  = '{4'b0111, 32'h33A01100, 4'b1011, 1'b1, 4'b0100, 1'b1, 8'hA0, 1'b0, 2'd2};
        tbl[8]  = '{4'b0111, 32'h33A11100, 4'b1011, 1'b1, 4'b0100, 1'b1, 8'hA1, 1'b0, 2'd2};
        tbl[9]  = '{4'b0111, 32'h33A21100, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b1, 2'd2};
        // ch3 not valid: search 3,0 -> ch0
        tbl[10] = '{4'b0011, 32'h33A21144, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h44, 1'b1, 2'd0};
        // backpressure on ch1
        tbl[11] = '{4'b0010, 32'h00005500, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h55, 1'b1, 2'd1};
        tbl[12] = '{4'b0010, 32'h00005600, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd1};
        tbl[13] = '{4'b0010, 32'h00005600, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd1};
        tbl[14] = '{4'b0010, 32'h00005600, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd1};
        tbl[15] = '{4'b0010, 32'h00005600, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd1};
        tbl[16] = '{4'b0010, 32'h00005600, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h56, 1'b1, 2'd1};
        // ch0 locks, then stalls while ch3 waits
        tbl[17] = '{4'b0001, 32'h330000B0, 4'b1110, 1'b1, 4'b0001, 1'b1, 8'hB0, 1'b0, 2'd0};
        tbl[18] = '{4'b1000, 32'h330000B0, 4'b1110, 1'b1, 4'b0000, 1'b0, 8'hB0, 1'b0, 2'd0};
        tbl[19] = '{4'b1000, 32'h330000B0, 4'b1110, 1'b1, 4'b0000, 1'b0, 8'hB0, 1'b0, 2'd0};
        tbl[20] = '{4'b1001, 32'h330000B1, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hB1, 1'b1, 2'd0};
        // sparse traffic: ch3 then ch0, pointer wraps
        tbl[21] = '{4'b1000, 32'h33000000, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3};
        tbl[22] = '{4'b0001, 32'h000000C0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hC0, 1'b1, 2'd0};
        tbl[23] = '{4'b0000, 32'h000000C0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hC0, 1'b1, 2'd0};

        // reset state, with inputs active to show in_ready is gated
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'hFFFFFFFF;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 0, 32'(in_ready), 32'h0);
        check("rst_out_valid", 0, 32'(out_valid), 32'h0);
        check("rst_out_data", 0, 32'(out_data), 32'h0);
        check("rst_out_sel", 0, 32'(out_sel), 32'h0);
        check("rst_out_last", 0, 32'(out_last), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            in_valid  = tbl[i].v;
            in_data   = tbl[i].d;
            in_last   = tbl[i].l;
            out_ready = tbl[i].ordy;
            #1;
            check("in_ready", i, 32'(in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            check("out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
            check("out_data", i, 32'(out_data), 32'(tbl[i].e_od));
            check("out_last", i, 32'(out_last), 32'(tbl[i].e_ol));
            check("out_sel", i, 32'(out_sel), 32'(tbl[i].e_os));
        end

        // async reset in the middle of a ch2 packet
        @(negedge clk);
        in_valid  = 4'b0100;
        in_data   = 32'h00D00000;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pkt_out_data", 0, 32'(out_data), 32'hD0);
        check("pkt_out_sel", 0, 32'(out_sel), 32'd2);
        in_valid = 4'b1010;
        in_data  = 32'hF3D0E100;
        in_last  = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 0, 32'(out_valid), 32'h0);
        check("arst_out_data", 0, 32'(out_data), 32'h0);
        check("arst_out_sel", 0, 32'(out_sel), 32'h0);
        check("arst_out_last", 0, 32'(out_last), 32'h0);
        check("arst_in_ready", 0, 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 0, 32'(in_ready), 32'b0010);
        @(posedge clk);
        #1;
        check("post_rst_out_valid", 0, 32'(out_valid), 32'h1);
        check("post_rst_out_data", 0, 32'(out_data), 32'hE1);
        check("post_rst_out_sel", 0, 32'(out_sel), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
